// File: rtl/spinner_decoder.sv
// ============================================================================
// Module      : spinner_decoder
// Description : Quadrature (AB) spinner decoder. It provides a position
//               counter, a saturating delta accumulator that is read and
//               cleared on rd_strobe, a step pulse, a direction flag and a
//               sticky error flag.
//               The optional glitch filter is enabled by defining
//               SPINNER_DECODER_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spinner_decoder #(
    parameter int CNT_W      = 8,
    parameter int FILTER_LEN = 4
) (
    input  logic             clk_12m,
    input  logic             reset,
    input  logic [1:0]       spinner,
    input  logic             rd_strobe,
    output logic [CNT_W-1:0] pos,
    output logic [CNT_W-1:0] delta,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_one       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_minus_one = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_delta_max = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] c_delta_min = {1'b1, {(CNT_W-1){1'b0}}};

    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_acc;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] r_delta;
    logic [CNT_W-1:0] r_acc_delta;
    logic             r_step;
    logic             r_dir;
    logic             r_err;

    logic             w_accept;
    logic [1:0]       w_move;
    logic             w_fwd;
    logic             w_rev;
    logic             w_ill;
    logic [CNT_W-1:0] w_delta_inc;
    logic [CNT_W-1:0] w_delta_dec;

    // Gray phase index: 00->0, 10->1, 11->2, 01->3 (bit1 = A, bit0 = B).
    function automatic logic [1:0] f_phase(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

`ifdef SPINNER_DECODER_GLITCH_FILTER_EN
    localparam logic [3:0] c_filt_last = 4'(FILTER_LEN - 1);

    logic [1:0] r_s2_q;
    logic [3:0] r_filt_cnt;
    logic       w_s2_changed;

    assign w_s2_changed = (r_s2 != r_s2_q);
    // r_filt_cnt holds how many earlier cycles the candidate has already been stable.
    assign w_accept     = (r_s2 != r_acc) && !w_s2_changed && (r_filt_cnt == c_filt_last);

    always_ff @(posedge clk_12m) begin
        if (!reset) begin
            r_s2_q     <= 2'b11;
            r_filt_cnt <= 4'd0;
        end else begin
            r_s2_q <= r_s2;
            if ((r_s2 == r_acc) || w_accept) begin
                r_filt_cnt <= 4'd0;
            end else if (w_s2_changed) begin
                r_filt_cnt <= 4'd1;
            end else begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
            end
        end
    end
`else
    logic [3:0] w_unused_filter_len;

    assign w_unused_filter_len = 4'(FILTER_LEN);
    assign w_accept            = (r_s2 != r_acc);
`endif

    assign w_move      = f_phase(r_s2) - f_phase(r_acc);
    assign w_fwd       = w_accept && (w_move == 2'd1);
    assign w_rev       = w_accept && (w_move == 2'd3);
    assign w_ill       = w_accept && (w_move == 2'd2);
    assign w_delta_inc = (r_acc_delta == c_delta_max) ? r_acc_delta : r_acc_delta + c_one;
    assign w_delta_dec = (r_acc_delta == c_delta_min) ? r_acc_delta : r_acc_delta - c_one;

    always_ff @(posedge clk_12m) begin
        if (!reset) begin
            r_s1        <= 2'b11;
            r_s2        <= 2'b11;
            r_acc       <= 2'b11;
            r_pos       <= '0;
            r_delta     <= '0;
            r_acc_delta <= '0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_s1   <= spinner;
            r_s2   <= r_s1;
            r_step <= 1'b0;

            if (w_accept) begin
                r_acc <= r_s2;
            end
            if (w_ill) begin
                r_err <= 1'b1;
            end

            if (w_fwd) begin
                r_pos  <= r_pos + c_one;
                r_dir  <= 1'b1;
                r_step <= 1'b1;
            end else if (w_rev) begin
                r_pos  <= r_pos - c_one;
                r_dir  <= 1'b0;
                r_step <= 1'b1;
            end

            // A read that coincides with a step hands out the pre-step value
            // and seeds the accumulator with that step so nothing is lost.
            if (rd_strobe) begin
                r_delta <= r_acc_delta;
                if (w_fwd) begin
                    r_acc_delta <= c_one;
                end else if (w_rev) begin
                    r_acc_delta <= c_minus_one;
                end else begin
                    r_acc_delta <= '0;
                end
            end else if (w_fwd) begin
                r_acc_delta <= w_delta_inc;
            end else if (w_rev) begin
                r_acc_delta <= w_delta_dec;
            end
        end
    end

    assign pos   = r_pos;
    assign delta = r_delta;
    assign step  = r_step;
    assign dir   = r_dir;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spinner_decoder.sv
// ============================================================================
// Module      : tb_spinner_decoder
// Description : Self-checking bench for spinner_decoder built from a
//               directed vector table and hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spinner_decoder;

`ifdef SPINNER_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        bit         rst;
        logic [1:0] pins;
        int         cyc;
        bit         rd;
        logic [7:0] pos;
        bit         dir;
        bit         err;
        int         steps;
        logic [7:0] delta;
    } vec_t;

    logic       clk_12m;
    logic       reset;
    logic [1:0] spinner;
    logic       rd_strobe;
    logic [7:0] pos;
    logic [7:0] delta;
    logic       step;
    logic       dir;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int step_cnt = 0;
    int long_pulse = 0;
    int steps_base = 0;
    logic step_prev = 1'b0;

    vec_t tbl [16];
    logic [1:0] fwd [4];

    spinner_decoder #(.CNT_W(8), .FILTER_LEN(4)) dut (
        .clk_12m   (clk_12m),
        .reset     (reset),
        .spinner   (spinner),
        .rd_strobe (rd_strobe),
        .pos       (pos),
        .delta     (delta),
        .step      (step),
        .dir       (dir),
        .err       (err)
    );

    initial clk_12m = 1'b0;
    always #5 clk_12m = ~clk_12m;

    always @(negedge clk_12m) begin
        if (step) step_cnt = step_cnt + 1;
        if (step && step_prev) long_pulse = long_pulse + 1;
        step_prev = step;
    end

    task automatic tick();
        @(posedge clk_12m);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        spinner   = 2'b11;
        rd_strobe = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        steps_base = step_cnt;
    endtask

    task automatic hold(input logic [1:0] p, input int n);
        spinner = p;
        repeat (n) tick();
    endtask

    initial begin
        fwd[0] = 2'b01; fwd[1] = 2'b00; fwd[2] = 2'b10; fwd[3] = 2'b11;

        //             rst pins   cyc rd  pos    dir err steps delta
        tbl[0]  = '{1, 2'b11,  5, 0, 8'h00, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 2'b01, 20, 0, 8'h01, 1, 0, 1, 8'h00};
        tbl[2]  = '{0, 2'b00, 20, 0, 8'h02, 1, 0, 2, 8'h00};
        tbl[3]  = '{0, 2'b10, 20, 0, 8'h03, 1, 0, 3, 8'h00};
        tbl[4]  = '{0, 2'b11, 20, 0, 8'h04, 1, 0, 4, 8'h00};
        tbl[5]  = '{0, 2'b11, 20, 1, 8'h04, 1, 0, 4, 8'h04};
        tbl[6]  = '{1, 2'b11,  5, 0, 8'h00, 0, 0, 0, 8'h00};
        tbl[7]  = '{0, 2'b10, 20, 0, 8'hFF, 0, 0, 1, 8'h00};
        tbl[8]  = '{0, 2'b00, 20, 0, 8'hFE, 0, 0, 2, 8'h00};
        tbl[9]  = '{0, 2'b01, 20, 0, 8'hFD, 0, 0, 3, 8'h00};
        tbl[10] = '{0, 2'b11, 20, 0, 8'hFC, 0, 0, 4, 8'h00};
        tbl[11] = '{0, 2'b11, 20, 1, 8'hFC, 0, 0, 4, 8'hFC};
        tbl[12] = '{0, 2'b11, 20, 1, 8'hFC, 0, 0, 4, 8'h00};
        tbl[13] = '{0, 2'b00, 20, 0, 8'hFC, 0, 1, 4, 8'h00};
        tbl[14] = '{0, 2'b10, 20, 0, 8'hFD, 1, 1, 5, 8'h00};
        tbl[15] = '{1, 2'b11,  5, 0, 8'h00, 0, 0, 0, 8'h00};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            spinner   = tbl[i].pins;
            rd_strobe = tbl[i].rd;
            tick();
            rd_strobe = 1'b0;
            repeat (tbl[i].cyc - 1) tick();
            check($sformatf("row%0d_pos", i),   int'(pos),   int'(tbl[i].pos));
            check($sformatf("row%0d_dir", i),   int'(dir),   int'(tbl[i].dir));
            check($sformatf("row%0d_err", i),   int'(err),   int'(tbl[i].err));
            check($sformatf("row%0d_steps", i), step_cnt - steps_base, tbl[i].steps);
            check($sformatf("row%0d_delta", i), int'(delta), int'(tbl[i].delta));
        end

        // Reset ignores pins and rd_strobe; idle pins give no spurious step.
        reset = 1'b0; spinner = 2'b00; rd_strobe = 1'b1;
        repeat (3) tick();
        steps_base = step_cnt;
        spinner = 2'b11; rd_strobe = 1'b0; reset = 1'b1;
        repeat (10) tick();
        check("rst_ignore_pos",   int'(pos),   0);
        check("rst_ignore_err",   int'(err),   0);
        check("rst_ignore_delta", int'(delta), 0);
        check("rst_ignore_steps", step_cnt - steps_base, 0);

        // Pin-to-pos latency and single-cycle step.
        do_reset();
        repeat (2) tick();
        spinner = 2'b01;
        repeat (LAT - 1) tick();
        check("lat_pos_early",  int'(pos),  0);
        check("lat_step_early", int'(step), 0);
        tick();
        check("lat_pos",  int'(pos),  1);
        check("lat_step", int'(step), 1);
        tick();
        check("lat_step_end", int'(step), 0);

        // 300 forward steps: pos wraps, accumulator saturates.
        do_reset();
        for (int i = 0; i < 300; i++) hold(fwd[i % 4], 8);
        repeat (8) tick();
        check("wrap_pos", int'(pos), 44);
        check("wrap_dir", int'(dir), 1);
        rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
        check("sat_delta", int'(delta), 127);
        repeat (3) tick();
        rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
        check("sat_delta_clear", int'(delta), 0);

        // rd_strobe coinciding with the 6th forward step.
        do_reset();
        for (int i = 0; i < 5; i++) hold(fwd[i % 4], 10);
        check("coin_pre_pos", int'(pos), 5);
        spinner = fwd[1];
        repeat (LAT - 1) tick();
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        check("coin_step",  int'(step),  1);
        check("coin_pos",   int'(pos),   6);
        check("coin_delta", int'(delta), 5);
        repeat (10) tick();
        rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
        check("coin_delta_next", int'(delta), 1);

`ifdef SPINNER_DECODER_GLITCH_FILTER_EN
        // Short glitch rejected, then a qualified hold yields one step.
        do_reset();
        repeat (2) tick();
        hold(2'b01, 3);
        hold(2'b11, 20);
        check("glitch_pos",   int'(pos), 0);
        check("glitch_err",   int'(err), 0);
        check("glitch_steps", step_cnt - steps_base, 0);
        spinner = 2'b01;
        repeat (5) tick();
        check("filt_pos_early", int'(pos), 0);
        tick();
        check("filt_pos",  int'(pos),  1);
        check("filt_step", int'(step), 1);
        repeat (20) tick();
        check("filt_steps", step_cnt - steps_base, 1);
`endif

        check("step_one_cycle", long_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
